// File: rtl/tpu_uart_pkg.sv
// Shared types and constants for the UART transmit path inside tpu_top.
//   arb_state_t   : arbiter FSM state (IDLE / GRANT0 / GRANT1)
//   NUM_ARB_PORTS : number of packet sources sharing the TX channel
//   BYTE_W        : width of one UART byte
//   grant_onehot  : maps an arbiter state to its one-hot grant vector
package tpu_uart_pkg;

    localparam int NUM_ARB_PORTS = 2;
    localparam int BYTE_W        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    function automatic logic [NUM_ARB_PORTS-1:0] grant_onehot(input arb_state_t s);
        logic [NUM_ARB_PORTS-1:0] g;
        g = '0;
        case (s)
            GRANT0:  g = 2'b01;
            GRANT1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/tx_hold_reg.sv
// One-entry output register between the arbiter and the UART TX serializer.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : a byte is accepted from the granted source this cycle
//   data_i      : the accepted byte
//   tx_ready_i  : serializer takes the held byte this cycle
//   tx_data_o   : held byte
//   tx_valid_o  : held byte is valid
module tx_hold_reg
    import tpu_uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] data_i,
    input  logic              tx_ready_i,
    output logic [BYTE_W-1:0] tx_data_o,
    output logic              tx_valid_o
);

    logic [BYTE_W-1:0] data_q;
    logic              valid_q;

    // A load in the same cycle as a drain replaces the entry, which is what
    // gives back-to-back bytes at full rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else if (tx_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet arbiter sharing the UART TX byte channel between the command-response
// path (port 0, priority) and the debug/telemetry streamer (port 1).
// Whole packets are granted; port 1 is guaranteed a grant after MAX_CONSEC
// back-to-back port-0 packets, and a source that goes silent mid-packet loses
// its grant after TIMEOUT_CYCLES idle cycles.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   req0_* / req1_*                    : source byte channels (data/valid/last/ready)
//   tx_data, tx_valid, tx_ready        : byte channel to the serializer
//   grant_dbg                          : one-hot current grant, 00 = idle
//   timeout_pulse, timeout_cnt         : forced-release strobe and saturating count
//
// state  | meaning
// IDLE   | no grant; arbitrate on current valids
// GRANT0 | port 0 owns the channel until its last byte or a timeout
// GRANT1 | port 1 owns the channel until its last byte or a timeout
module uart_tx_arbiter
    import tpu_uart_pkg::*;
#(
    parameter int MAX_CONSEC     = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BYTE_W-1:0]        req0_data,
    input  logic                     req0_valid,
    input  logic                     req0_last,
    output logic                     req0_ready,
    input  logic [BYTE_W-1:0]        req1_data,
    input  logic                     req1_valid,
    input  logic                     req1_last,
    output logic                     req1_ready,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [NUM_ARB_PORTS-1:0] grant_dbg,
    output logic                     timeout_pulse,
    output logic [CNT_W-1:0]         timeout_cnt
);

    localparam int IDLE_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int STARVE_W = $clog2(MAX_CONSEC + 1);
    localparam logic [IDLE_W-1:0]   IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_CONSEC);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic                timeout_pulse_q, timeout_pulse_d;
    logic [CNT_W-1:0]    timeout_cnt_q, timeout_cnt_d;

    logic              out_free;
    logic              accept0, accept1, accept;
    logic              acc_last;
    logic              gnt_valid;
    logic [BYTE_W-1:0] acc_data;

    // The output entry can take a byte if it is empty or draining this cycle.
    assign out_free   = !tx_valid || tx_ready;
    assign req0_ready = (state_q == GRANT0) && out_free;
    assign req1_ready = (state_q == GRANT1) && out_free;
    assign accept0    = req0_valid && req0_ready;
    assign accept1    = req1_valid && req1_ready;
    assign accept     = accept0 || accept1;
    assign acc_data   = accept1 ? req1_data : req0_data;
    assign acc_last   = accept1 ? req1_last : req0_last;
    assign gnt_valid  = (state_q == GRANT1) ? req1_valid : req0_valid;

    always_comb begin
        state_d         = state_q;
        starve_cnt_d    = starve_cnt_q;
        idle_cnt_d      = '0;
        timeout_pulse_d = 1'b0;
        timeout_cnt_d   = timeout_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = (starve_cnt_q == STARVE_MAX) ? GRANT1 : GRANT0;
                end else if (req0_valid) begin
                    state_d = GRANT0;
                end else if (req1_valid) begin
                    state_d = GRANT1;
                end
                // A port-0 grant only counts against fairness if port 1 was waiting.
                if (state_d == GRANT1) begin
                    starve_cnt_d = '0;
                end else if (state_d == GRANT0 && req1_valid && starve_cnt_q != STARVE_MAX) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end
            GRANT0, GRANT1: begin
                if (accept && acc_last) begin
                    state_d = IDLE;
                end else if (!gnt_valid) begin
                    // Only a silent source ages the lock; a serializer stall with
                    // valid held high keeps idle_cnt at zero.
                    if (idle_cnt_q == IDLE_LIMIT) begin
                        state_d         = IDLE;
                        timeout_pulse_d = 1'b1;
                        if (timeout_cnt_q != {CNT_W{1'b1}}) begin
                            timeout_cnt_d = timeout_cnt_q + 1'b1;
                        end
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            starve_cnt_q    <= '0;
            idle_cnt_q      <= '0;
            timeout_pulse_q <= 1'b0;
            timeout_cnt_q   <= '0;
        end else begin
            state_q         <= state_d;
            starve_cnt_q    <= starve_cnt_d;
            idle_cnt_q      <= idle_cnt_d;
            timeout_pulse_q <= timeout_pulse_d;
            timeout_cnt_q   <= timeout_cnt_d;
        end
    end

    tx_hold_reg u_hold (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .data_i     (acc_data),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid)
    );

    assign grant_dbg     = grant_onehot(state_q);
    assign timeout_pulse = timeout_pulse_q;
    assign timeout_cnt   = timeout_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int MAXC  = 4;
    localparam int TO    = 16;
    localparam int CW    = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req0_data = '0, req1_data = '0;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [1:0] grant_dbg;
    logic       timeout_pulse;
    logic [CW-1:0] timeout_cnt;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.MAX_CONSEC(MAXC), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
        .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant_dbg(grant_dbg), .timeout_pulse(timeout_pulse), .timeout_cnt(timeout_cnt)
    );

    int checks = 0, errors = 0, cyc_n = 0;
    int rdy_mode = 0;                       // 0: always ready, 1: random, 2: stalled
    logic [7:0] q0_d[$], q1_d[$];           // pending source bytes
    bit         q0_l[$], q1_l[$];
    logic [7:0] dlog[$];                    // bytes seen leaving on tx
    logic [7:0] exp_s[$];                   // expected tx byte stream for directed tests
    int         glog[$];                    // order of new grants observed
    logic [1:0] prev_grant = 2'b00;
    int         pulse_cyc = -1, acc_cyc = -1;

    // Reference model: owner of the channel (-1 none), fairness counter,
    // silence counter of the owner, one-entry output buffer, timeout stats.
    int         m_own = -1, m_starve = 0, m_idle = 0, m_tocnt = 0;
    bit         m_hv = 1'b0, m_pulse = 1'b0;
    logic [7:0] m_hd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic push_byte(input int p, input logic [7:0] d, input bit l);
        if (p == 0) begin q0_d.push_back(d); q0_l.push_back(l); end
        else        begin q1_d.push_back(d); q1_l.push_back(l); end
    endtask

    task automatic push_rand_pkt(input int p);
        int len;
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) push_byte(p, 8'($urandom), i == len - 1);
    endtask

    task automatic model_reset();
        m_own = -1; m_starve = 0; m_idle = 0; m_tocnt = 0;
        m_hv = 1'b0; m_pulse = 1'b0; m_hd = '0;
        prev_grant = 2'b00;
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, 32'(dlog.size()), 32'(exp_s.size()));
        for (int i = 0; i < dlog.size() && i < exp_s.size(); i++)
            chk({tag, "_byte"}, 32'(dlog[i]), 32'(exp_s[i]));
    endtask

    task automatic cyc();
        bit v0, v1, mr0, mr1, acc, lst, own_v;
        int nxt;
        logic [7:0] d;
        @(posedge clk); #1;
        cyc_n++;
        chk("grant_dbg", 32'(grant_dbg), (m_own < 0) ? 32'd0 : (m_own == 0 ? 32'd1 : 32'd2));
        chk("tx_valid", 32'(tx_valid), 32'(m_hv));
        if (m_hv) chk("tx_data", 32'(tx_data), 32'(m_hd));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
        chk("timeout_cnt", 32'(timeout_cnt), 32'(m_tocnt));
        if (timeout_pulse) pulse_cyc = cyc_n;
        if (prev_grant == 2'b00 && grant_dbg != 2'b00) glog.push_back(grant_dbg == 2'b10 ? 1 : 0);
        prev_grant = grant_dbg;

        req0_valid = q0_d.size() > 0;
        if (req0_valid) begin req0_data = q0_d[0]; req0_last = q0_l[0]; end
        else begin req0_data = 8'($urandom); req0_last = 1'($urandom); end
        req1_valid = q1_d.size() > 0;
        if (req1_valid) begin req1_data = q1_d[0]; req1_last = q1_l[0]; end
        else begin req1_data = 8'($urandom); req1_last = 1'($urandom); end
        if (rdy_mode == 0)      tx_ready = 1'b1;
        else if (rdy_mode == 2) tx_ready = 1'b0;
        else                    tx_ready = ($urandom_range(0, 9) < 7);
        #1;

        v0  = req0_valid;
        v1  = req1_valid;
        mr0 = (m_own == 0) && (!m_hv || tx_ready);
        mr1 = (m_own == 1) && (!m_hv || tx_ready);
        chk("req0_ready", 32'(req0_ready), 32'(mr0));
        chk("req1_ready", 32'(req1_ready), 32'(mr1));
        if (tx_valid && tx_ready) dlog.push_back(tx_data);

        acc   = (v0 && mr0) || (v1 && mr1);
        d     = (m_own == 1) ? req1_data : req0_data;
        lst   = (m_own == 1) ? req1_last : req0_last;
        own_v = (m_own == 1) ? v1 : v0;
        nxt   = m_own;
        m_pulse = 1'b0;
        if (m_own < 0) begin
            if (v0 && v1)  nxt = (m_starve == MAXC) ? 1 : 0;
            else if (v0)   nxt = 0;
            else if (v1)   nxt = 1;
            if (nxt == 1)               m_starve = 0;
            else if (nxt == 0 && v1)    m_starve = (m_starve < MAXC) ? m_starve + 1 : MAXC;
            m_idle = 0;
        end else if (acc && lst) begin
            nxt = -1; m_idle = 0;
        end else if (!own_v) begin
            if (m_idle == TO - 1) begin
                nxt = -1; m_idle = 0; m_pulse = 1'b1;
                if (m_tocnt < CNT_MAX) m_tocnt++;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
        if (acc) begin m_hv = 1'b1; m_hd = d; end
        else if (tx_ready) m_hv = 1'b0;
        m_own = nxt;

        if (req0_valid && req0_ready) begin void'(q0_d.pop_front()); void'(q0_l.pop_front()); end
        if (req1_valid && req1_ready) begin void'(q1_d.pop_front()); void'(q1_l.pop_front()); acc_cyc = cyc_n; end
    endtask

    initial begin
        #1ms;
        errors++;
        $display("FAIL watchdog: simulation did not complete, observed=running required=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int drop_cyc, gmask;
        // ---- reset state
        #12;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_grant", 32'(grant_dbg), 0);
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_pulse", 32'(timeout_pulse), 0);
        chk("rst_tocnt", 32'(timeout_cnt), 0);
        @(negedge clk); rst_n = 1'b1;

        // ---- single port-0 packet
        rdy_mode = 0; dlog.delete(); exp_s.delete();
        push_byte(0, 8'hA1, 0); push_byte(0, 8'hA2, 0); push_byte(0, 8'hA3, 1);
        exp_s = '{8'hA1, 8'hA2, 8'hA3};
        repeat (8) cyc();
        check_stream("t1");
        chk("t1_grant_end", 32'(grant_dbg), 0);

        // ---- fairness: both ports stream 2-byte packets
        dlog.delete(); exp_s.delete(); glog.delete();
        for (int k = 0; k < 8; k++) begin push_byte(0, 8'(8'h10 + k), 0); push_byte(0, 8'(8'h20 + k), 1); end
        for (int k = 0; k < 2; k++) begin push_byte(1, 8'(8'hB0 + k), 0); push_byte(1, 8'(8'hC0 + k), 1); end
        for (int k = 0; k < 4; k++) begin exp_s.push_back(8'(8'h10 + k)); exp_s.push_back(8'(8'h20 + k)); end
        exp_s.push_back(8'hB0); exp_s.push_back(8'hC0);
        for (int k = 4; k < 8; k++) begin exp_s.push_back(8'(8'h10 + k)); exp_s.push_back(8'(8'h20 + k)); end
        exp_s.push_back(8'hB1); exp_s.push_back(8'hC1);
        for (int i = 0; i < 200 && (q0_d.size() + q1_d.size()) > 0; i++) cyc();
        repeat (3) cyc();
        chk("t2_drain", 32'(q0_d.size() + q1_d.size()), 0);
        gmask = 0;
        for (int i = 0; i < glog.size(); i++) gmask |= glog[i] << i;
        chk("t2_grants", 32'(glog.size()), 10);
        chk("t2_order", 32'(gmask), 32'h210);
        check_stream("t2");

        // ---- serializer stall mid-packet must not time out
        dlog.delete(); exp_s = '{8'h31, 8'h32, 8'h33, 8'h34}; pulse_cyc = -1;
        push_byte(0, 8'h31, 0); push_byte(0, 8'h32, 0); push_byte(0, 8'h33, 0); push_byte(0, 8'h34, 1);
        for (int i = 0; i < 20 && q0_d.size() != 2; i++) cyc();
        chk("t3_half", 32'(q0_d.size()), 2);
        rdy_mode = 2;
        repeat (20) cyc();
        chk("t3_no_pulse", 32'(pulse_cyc), 32'(-1));
        rdy_mode = 0;
        for (int i = 0; i < 20 && q0_d.size() > 0; i++) cyc();
        repeat (3) cyc();
        check_stream("t3");
        chk("t3_tocnt", 32'(timeout_cnt), 0);

        // ---- port 1 goes silent mid-packet
        dlog.delete(); glog.delete(); pulse_cyc = -1; acc_cyc = -1;
        push_byte(1, 8'h55, 0);
        for (int i = 0; i < 10 && q1_d.size() > 0; i++) cyc();
        drop_cyc = acc_cyc + 1;
        push_byte(0, 8'h61, 0); push_byte(0, 8'h62, 1);
        repeat (25) cyc();
        chk("t4_pulse_delay", 32'(pulse_cyc - drop_cyc), 16);
        chk("t4_tocnt", 32'(timeout_cnt), 1);
        chk("t4_first_byte", 32'(dlog.size() > 0 ? dlog[0] : 8'h00), 32'h55);
        chk("t4_grants", 32'(glog.size()), 2);
        chk("t4_next_grant", 32'(glog.size() > 1 ? glog[1] : -1), 0);
        chk("t4_drain", 32'(q0_d.size()), 0);

        // ---- asynchronous reset mid-packet
        push_byte(0, 8'h71, 0); push_byte(0, 8'h72, 0); push_byte(0, 8'h73, 0); push_byte(0, 8'h74, 1);
        for (int i = 0; i < 20 && q0_d.size() != 2; i++) cyc();
        #2; rst_n = 1'b0; #1;
        chk("t5_tx_valid", 32'(tx_valid), 0);
        chk("t5_grant", 32'(grant_dbg), 0);
        chk("t5_ready0", 32'(req0_ready), 0);
        chk("t5_ready1", 32'(req1_ready), 0);
        chk("t5_tocnt", 32'(timeout_cnt), 0);
        model_reset();
        q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        dlog.delete(); exp_s = '{8'h81, 8'h82, 8'h83, 8'h84};
        push_byte(0, 8'h81, 0); push_byte(0, 8'h82, 0); push_byte(0, 8'h83, 0); push_byte(0, 8'h84, 1);
        for (int i = 0; i < 20 && q0_d.size() > 0; i++) cyc();
        repeat (3) cyc();
        check_stream("t5");

        // ---- timeout counter saturation
        for (int n = 0; n < 256; n++) begin
            push_byte(1, 8'(n), 0);
            for (int i = 0; i < 10 && q1_d.size() > 0; i++) cyc();
            repeat (18) cyc();
        end
        chk("t6_tocnt_sat", 32'(timeout_cnt), 32'hFF);

        // ---- random traffic with random serializer back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 800; i++) begin
            if (q0_d.size() == 0 && $urandom_range(0, 2) == 0) push_rand_pkt(0);
            if (q1_d.size() == 0 && $urandom_range(0, 2) == 0) push_rand_pkt(1);
            cyc();
        end
        rdy_mode = 0;
        for (int i = 0; i < 100 && (q0_d.size() + q1_d.size()) > 0; i++) cyc();
        repeat (3) cyc();
        chk("t7_drain", 32'(q0_d.size() + q1_d.size()), 0);
        chk("t7_tocnt", 32'(timeout_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmit byte channel between two packet sources: the command-response path of the UART controller (port 0) and a debug/telemetry streamer (port 1). It grants whole packets, so bytes from different packets are never interleaved. Port 0 has priority, with a starvation guard for port 1 and a stall timeout. It sits inside tpu_top, between the packet sources and the UART TX serializer.

Parameters:
MAX_CONSEC, 4, max back-to-back port-0 packets granted while port 1 is waiting
TIMEOUT_CYCLES, 1_000_000, idle cycles of the granted source before its lock is forcibly released (10 ms at 100 MHz)
CNT_W, 8, width of the saturating timeout event counter

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
req0_data  in  8  port-0 byte
req0_valid  in  1  port-0 byte valid
req0_last  in  1  port-0 final byte of packet
req0_ready  out  1  port-0 byte accepted
req1_data  in  8  port-1 byte
req1_valid  in  1  port-1 byte valid
req1_last  in  1  port-1 final byte of packet
req1_ready  out  1  port-1 byte accepted
tx_data  out  8  byte to serializer
tx_valid  out  1  tx_data valid
tx_ready  in  1  serializer accepts byte
grant_dbg  out  2  one-hot current grant; 00 = idle
timeout_pulse  out  1  one-cycle strobe on forced release
timeout_cnt  out  CNT_W  saturating count of timeouts

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; tx_valid=0; tx_data=0; grant_dbg=00; req*_ready=0; timeout_pulse=0; timeout_cnt=0; starve_cnt=0; idle_cnt=0. Any in-flight packet is dropped, with no recovery.
- FSM states: IDLE, GRANT0, GRANT1. State is registered; grant_dbg is a direct decode of the state.
- Arbitration in IDLE, one cycle, decided on the current req*_valid:
  - only req0_valid -> GRANT0
  - only req1_valid -> GRANT1
  - both valid -> GRANT1 if starve_cnt==MAX_CONSEC, else GRANT0
  - neither valid -> stay in IDLE
- Starvation guard:
  - starve_cnt increments (saturating at MAX_CONSEC) when a GRANT0 is issued while req1_valid=1.
  - starve_cnt clears when GRANT1 is issued.
- Output stage: a one-entry register (tx_data/tx_valid).
  - reqN_ready = (state==GRANTN) && (!tx_valid || tx_ready). This is combinational and holds no payload.
  - On reqN_valid && reqN_ready: tx_data<=reqN_data and tx_valid<=1 on the next edge. Latency is one cycle from accept to tx_valid.
  - tx_valid clears when tx_ready=1 and no new byte is accepted in the same cycle.
  - A simultaneous tx_ready handshake and new accept keeps tx_valid=1 with the new data, giving full throughput of 1 byte/cycle.
- Packet end: when a byte with reqN_last=1 is accepted, the next state is IDLE. The new grant therefore starts one cycle later, giving a one-cycle arbitration bubble per packet. The last byte still drains through the output register normally.
- Timeout:
  - In GRANTN, idle_cnt increments each cycle that reqN_valid=0, and clears on any accepted byte or on a state change.
  - When idle_cnt reaches TIMEOUT_CYCLES-1 with reqN_valid still 0, the next state is IDLE, timeout_pulse=1 for exactly one cycle, and timeout_cnt increments (saturating at all-ones). The already-buffered byte is still delivered.
  - Stall caused by tx_ready=0 (reqN_valid=1, ready=0) does NOT count toward the timeout.
- A non-granted port's valid is ignored. Its ready stays 0, and its data may change freely.
- The grant never changes mid-packet except by timeout or reset.
- reqN_last on a packet of length 1 is legal; IDLE follows immediately.

Decomposition:
- Shared package tpu_uart_pkg:
  - enum arb_state_t {IDLE, GRANT0, GRANT1}
  - localparams NUM_ARB_PORTS=2, BYTE_W=8
- One natural sub-module: tx_hold_reg (the one-entry valid/ready output register). The FSM, counters and ready decode stay in uart_tx_arbiter.

Test Plan:
- Single port-0 packet 0xA1,0xA2,0xA3 (last on 0xA3), tx_ready=1 -> grant_dbg=01 one cycle after req0_valid; tx_data sequence A1,A2,A3 on consecutive cycles; grant_dbg=00 after A3 is accepted.
- Both ports present 2-byte packets continuously, MAX_CONSEC=4 -> grant order 0,0,0,0,1,0,0,0,0,1; port-1 bytes are never interleaved inside a port-0 packet.
- tx_ready held 0 for 20 cycles mid-packet, TIMEOUT_CYCLES=16 -> tx_valid stays 1 with data unchanged, no timeout_pulse, and the packet completes after tx_ready returns to 1.
- Port 1 granted, sends 0x55 without last, then drops valid, TIMEOUT_CYCLES=16 -> 0x55 is delivered; timeout_pulse fires 16 cycles after valid drops; timeout_cnt=1; a pending port-0 packet is granted next.
- rst_n asserted low mid-packet (after 2 of 4 bytes) -> tx_valid, grant_dbg and req*_ready go to 0 without a clock edge; after release, a new packet from byte 0 goes out cleanly.
- 256 forced timeouts with CNT_W=8 -> timeout_cnt saturates at 0xFF, with no wrap.
